// File: rtl/ll_queue_ctrl_if.sv
// rtl/ll_queue_ctrl_if.sv - enqueue/dequeue streams and list-block link for ll_queue_ctrl (LLQ_OCCUPANCY_EN adds occupancy)
interface ll_queue_ctrl_if #(
    parameter int NUM_ELEMS  = 4,
    parameter int NUM_LISTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int QID_WIDTH  = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
);
    logic                           in_valid;
    logic                           in_ready;
    logic [QID_WIDTH-1:0]           in_qid;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [QID_WIDTH-1:0]           out_qid;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [NUM_LISTS-1:0]           push;
    logic [NUM_LISTS-1:0]           pop;
    logic                           ll_full;
    logic [NUM_LISTS-1:0]           ll_empty;
    logic [NUM_LISTS*PTR_WIDTH-1:0] ll_head;
    logic [NUM_LISTS*PTR_WIDTH-1:0] ll_tail;
`ifdef LLQ_OCCUPANCY_EN
    logic [NUM_LISTS*(PTR_WIDTH+1)-1:0] occupancy;
`endif

    modport slave (
        input  in_valid, in_qid, in_data,
        output in_ready,
        output out_valid, out_qid, out_data,
        input  out_ready,
        output push, pop,
        input  ll_full, ll_empty, ll_head, ll_tail
`ifdef LLQ_OCCUPANCY_EN
        , output occupancy
`endif
    );

    modport master (
        output in_valid, in_qid, in_data,
        input  in_ready,
        input  out_valid, out_qid, out_data,
        output out_ready,
        input  push, pop,
        output ll_full, ll_empty, ll_head, ll_tail
`ifdef LLQ_OCCUPANCY_EN
        , input occupancy
`endif
    );
endinterface

// File: rtl/ll_queue_ctrl.sv
// rtl/ll_queue_ctrl.sv - linked-list queue control/payload stage, round-robin dequeue (LLQ_OCCUPANCY_EN adds per-queue occupancy)
module ll_queue_ctrl #(
    parameter int NUM_ELEMS  = 4,
    parameter int NUM_LISTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int QID_WIDTH  = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input logic          clk,
    input logic          rst,
    ll_queue_ctrl_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem [NUM_ELEMS];
    logic [PTR_WIDTH-1:0]  heads [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  tails [NUM_LISTS];

    logic                  out_valid_q;
    logic [QID_WIDTH-1:0]  out_qid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  wr_pend;
    logic [QID_WIDTH-1:0]  wr_qid;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [QID_WIDTH-1:0]  rr_ptr;

    logic                  pop_go;
    logic                  push_go;
    logic [QID_WIDTH-1:0]  pop_qid;
    logic [PTR_WIDTH-1:0]  wr_addr;
    logic [PTR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [NUM_LISTS-1:0]  push_vec;
    logic [NUM_LISTS-1:0]  pop_vec;

    for (genvar g = 0; g < NUM_LISTS; g++) begin : g_unpack
        assign heads[g] = bus.ll_head[PTR_WIDTH*g +: PTR_WIDTH];
        assign tails[g] = bus.ll_tail[PTR_WIDTH*g +: PTR_WIDTH];
    end

    // Descending scan so the nearest non-empty list after 'last' wins.
    function automatic logic [QID_WIDTH-1:0] rr_pick(input logic [QID_WIDTH-1:0] last,
                                                     input logic [NUM_LISTS-1:0] nonempty);
        logic [QID_WIDTH-1:0] sel;
        logic [QID_WIDTH-1:0] idx;
        sel = last;
        for (int i = NUM_LISTS; i >= 1; i--) begin
            idx = QID_WIDTH'((int'(last) + i) % NUM_LISTS);
            if (nonempty[idx]) sel = idx;
        end
        return sel;
    endfunction

    always_comb begin
        pop_go   = (!out_valid_q || bus.out_ready) && (|(~bus.ll_empty));
        pop_qid  = rr_pick(rr_ptr, ~bus.ll_empty);
        push_go  = bus.in_valid && !bus.ll_full && !pop_go;
        wr_addr  = tails[wr_qid];
        rd_addr  = heads[pop_qid];
        // A slot pushed last cycle is only in wr_data_q until the write lands.
        rd_data  = (wr_pend && rd_addr == wr_addr) ? wr_data_q : mem[rd_addr];
        push_vec = push_go ? (NUM_LISTS'(1) << bus.in_qid) : '0;
        pop_vec  = pop_go ? (NUM_LISTS'(1) << pop_qid) : '0;
    end

    assign bus.in_ready  = !bus.ll_full && !pop_go;
    assign bus.push      = push_vec;
    assign bus.pop       = pop_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_qid   = out_qid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_qid_q   <= '0;
            out_data_q  <= '0;
            wr_pend     <= 1'b0;
            wr_qid      <= '0;
            wr_data_q   <= '0;
            rr_ptr      <= QID_WIDTH'(NUM_LISTS - 1);
        end else begin
            if (pop_go) begin
                out_valid_q <= 1'b1;
                out_qid_q   <= pop_qid;
                out_data_q  <= rd_data;
                rr_ptr      <= pop_qid;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (push_go) begin
                wr_pend   <= 1'b1;
                wr_qid    <= bus.in_qid;
                wr_data_q <= bus.in_data;
            end else begin
                wr_pend   <= 1'b0;
            end
        end
    end

    // The list block has already linked the new slot as tail when this write lands.
    always_ff @(posedge clk) begin
        if (!rst && wr_pend) mem[wr_addr] <= wr_data_q;
    end

`ifdef LLQ_OCCUPANCY_EN
    logic [PTR_WIDTH:0] occ [NUM_LISTS];
    for (genvar g = 0; g < NUM_LISTS; g++) begin : g_occ
        always_ff @(posedge clk) begin
            if (rst)              occ[g] <= '0;
            else if (push_vec[g]) occ[g] <= occ[g] + 1'b1;
            else if (pop_vec[g])  occ[g] <= occ[g] - 1'b1;
        end
        assign bus.occupancy[(PTR_WIDTH+1)*g +: PTR_WIDTH+1] = occ[g];
    end
`endif
endmodule

// File: tb/tb_ll_queue_ctrl.sv
// tb/tb_ll_queue_ctrl.sv - scoreboard bench for ll_queue_ctrl with a behavioural list block
module tb_ll_queue_ctrl;
    localparam int NE = 4;
    localparam int NL = 2;
    localparam int DW = 8;
    localparam int PW = 2;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ll_queue_ctrl_if #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .DATA_WIDTH(DW)) bus ();
    ll_queue_ctrl #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic          exp_order[$];

    task automatic push_exp(input logic qid, input logic [DW-1:0] d);
        if (qid) exp_q1.push_back(d);
        else     exp_q0.push_back(d);
    endtask

    // Behavioural shared-memory linked-list block.
    int unsigned m_head[NL];
    int unsigned m_tail[NL];
    int unsigned m_cnt[NL];
    int unsigned m_next[NE];
    int unsigned free_q[$];

    always @(posedge clk) begin
        logic [NL*PW-1:0] hv;
        logic [NL-1:0]    ev;
        int unsigned      s;
        if (rst) begin
            free_q = {};
            for (int i = 0; i < NE; i++) free_q.push_back(i);
            for (int q = 0; q < NL; q++) begin
                m_cnt[q] = 0; m_head[q] = 0; m_tail[q] = 0;
            end
            bus.ll_empty <= '1;
            bus.ll_full  <= 1'b0;
            bus.ll_head  <= '0;
            bus.ll_tail  <= '0;
        end else begin
            if (|bus.push || |bus.pop)
                check_eq("one_list_op", 32'($countones({bus.push, bus.pop})), 1);
            for (int q = 0; q < NL; q++) begin
                if (bus.pop[q]) begin
                    check_eq("pop_nonempty", 32'(m_cnt[q] != 0), 1);
                    if (m_cnt[q] != 0) begin
                        s = m_head[q];
                        m_head[q] = m_next[s];
                        m_cnt[q]--;
                        free_q.push_back(s);
                    end
                end
            end
            for (int q = 0; q < NL; q++) begin
                if (bus.push[q]) begin
                    check_eq("push_not_full", 32'(free_q.size() != 0), 1);
                    if (free_q.size() != 0) begin
                        s = free_q.pop_front();
                        if (m_cnt[q] == 0) m_head[q] = s;
                        else               m_next[m_tail[q]] = s;
                        m_tail[q] = s;
                        m_cnt[q]++;
                    end
                end
            end
            for (int q = 0; q < NL; q++) begin
                ev[q] = (m_cnt[q] == 0);
                hv[PW*q +: PW] = PW'(m_head[q]);
            end
            bus.ll_empty <= ev;
            bus.ll_full  <= (free_q.size() == 0);
            bus.ll_head  <= hv;
            for (int q = 0; q < NL; q++) hv[PW*q +: PW] = PW'(m_tail[q]);
            bus.ll_tail  <= hv;
        end
    end

    // Output monitor: handshake at the coming edge consumes one expectation.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        bit            have;
        if (!rst) begin
            if (bus.ll_full) check_eq("in_ready_when_full", 32'(bus.in_ready), 0);
`ifdef LLQ_OCCUPANCY_EN
            check_eq("occupancy_q0", 32'(bus.occupancy[2:0]), m_cnt[0]);
            check_eq("occupancy_q1", 32'(bus.occupancy[5:3]), m_cnt[1]);
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (exp_order.size() > 0) check_eq("rr_qid", 32'(bus.out_qid), 32'(exp_order.pop_front()));
                have = bus.out_qid ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
                check_eq("sb_expected", 32'(have), 1);
                if (have) begin
                    e = bus.out_qid ? exp_q1.pop_front() : exp_q0.pop_front();
                    check_eq("sb_data", 32'(bus.out_data), 32'(e));
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q0 = {}; exp_q1 = {}; exp_order = {};
    endtask

    task automatic send(input logic qid, input logic [DW-1:0] d, input int maxw, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_qid   = qid;
        bus.in_data  = d;
        for (int w = 0; w < maxw && !ok; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                push_exp(qid, d);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic bypass_check(input logic qid, input logic [DW-1:0] d);
        logic [NL-1:0] onehot;
        onehot = NL'(1) << qid;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_qid    = qid;
        bus.in_data   = d;
        @(negedge clk);
        check_eq("byp_push", 32'(bus.push), 32'(onehot));
        check_eq("byp_in_ready", 32'(bus.in_ready), 1);
        if (bus.in_ready) push_exp(qid, d);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("byp_pop", 32'(bus.pop), 32'(onehot));
        check_eq("byp_in_ready_pop", 32'(bus.in_ready), 0);
        check_eq("byp_out_valid_t1", 32'(bus.out_valid), 0);
        @(negedge clk);
        check_eq("byp_out_valid", 32'(bus.out_valid), 1);
        check_eq("byp_out_qid", 32'(bus.out_qid), 32'(qid));
        check_eq("byp_out_data", 32'(bus.out_data), 32'(d));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            done = (exp_q0.size() == 0 && exp_q1.size() == 0);
        end
        check_eq("drain_left", 32'(exp_q0.size() + exp_q1.size()), 0);
        check_eq("drain_idle", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int n_acc;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_qid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 1);
        check_eq("rst_push", 32'(bus.push), 0);
        check_eq("rst_pop", 32'(bus.pop), 0);
        check_eq("rst_out_qid", 32'(bus.out_qid), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        @(posedge clk); #1;

        bypass_check(1'b0, 8'hA1);
        bypass_check(1'b1, 8'hB2);
        @(posedge clk); #1;

        // Fill to full on q1 with output held, then backpressure, then drain.
        reset_dut();
        n_acc = 0;
        for (int i = 1; i <= 6; i++) begin
            send(1'b1, DW'(i), 6, ok);
            if (ok) n_acc++;
        end
        check_eq("fill_accepted", 32'(n_acc), 5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp_full", 32'(bus.ll_full), 1);
            check_eq("bp_out_valid", 32'(bus.out_valid), 1);
            check_eq("bp_out_data", 32'(bus.out_data), 32'h01);
            check_eq("bp_out_qid", 32'(bus.out_qid), 1);
            check_eq("bp_pop", 32'(bus.pop), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // Round-robin across two loaded lists.
        reset_dut();
        send(1'b0, 8'h10, 8, ok); check_eq("rr_accept", 32'(ok), 1);
        send(1'b0, 8'h11, 8, ok); check_eq("rr_accept", 32'(ok), 1);
        send(1'b0, 8'h12, 8, ok); check_eq("rr_accept", 32'(ok), 1);
        send(1'b1, 8'h20, 8, ok); check_eq("rr_accept", 32'(ok), 1);
        send(1'b1, 8'h21, 8, ok); check_eq("rr_accept", 32'(ok), 1);
        exp_order = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        wait_drain();
        check_eq("rr_order_left", 32'(exp_order.size()), 0);

        // Reset while the output register and a pending write are both live.
        reset_dut();
        send(1'b0, 8'h33, 8, ok); check_eq("rst_mid_accept", 32'(ok), 1);
        send(1'b0, 8'h44, 8, ok); check_eq("rst_mid_accept", 32'(ok), 1);
        check_eq("rst_mid_pre_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q0 = {}; exp_q1 = {}; exp_order = {};
        @(negedge clk);
        check_eq("rst_mid_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_mid_push", 32'(bus.push), 0);
        check_eq("rst_mid_pop", 32'(bus.pop), 0);
        @(posedge clk); #1;
        bypass_check(1'b0, 8'h55);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
